// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the fetch sequencer (master)
// and instruction memory (slave).
interface fetch_sequencer_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the five-stage MIPS pipeline: owns the PC, drives the
// instruction-memory handshake and loads the F/D register, honouring one delay slot.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  fetch_sequencer_if.master        imem,
  output logic                     ifd_valid,
  output logic [31:0]              ifd_instr,
  output logic [31:0]              ifd_pc8
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        load_fetch;
  logic        load_hold;
  logic        enter;
  logic        take_redirect;
  logic [31:0] next_pc;

  function automatic logic [31:0] pc_offset(input logic [31:0] base,
                                            input logic [31:0] off);
    return base + off;
  endfunction

  always_comb begin
    load_fetch    = (state == FETCH) && imem.im_ack && !stall;
    load_hold     = (state == HOLD) && !stall;
    enter         = load_fetch || load_hold;
    take_redirect = redirect && !stall;
    // A redirect seen while the delay slot was outstanding wins over a fresh one.
    if (pend_valid) begin
      next_pc = pend_pc;
    end else if (take_redirect) begin
      next_pc = redirect_pc;
    end else begin
      next_pc = pc_offset(pc, 32'd4);
    end
  end

  assign imem.im_req  = req_q;
  assign imem.im_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
      hold_instr <= 32'd0;
      hold_pc    <= 32'd0;
      ifd_valid  <= 1'b0;
      ifd_instr  <= 32'd0;
      ifd_pc8    <= 32'd0;
    end else begin
      // The PC only advances when an instruction actually lands in F/D.
      if (enter) begin
        pc         <= next_pc;
        pend_valid <= 1'b0;
      end else if (take_redirect) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end

      case (state)
        IDLE: begin
          ifd_valid <= 1'b0;
          ifd_instr <= 32'd0;
          ifd_pc8   <= 32'd0;
          state     <= FETCH;
          req_q     <= 1'b1;
        end

        FETCH: begin
          if (imem.im_ack) begin
            if (!stall) begin
              ifd_valid <= 1'b1;
              ifd_instr <= imem.im_rdata;
              ifd_pc8   <= pc_offset(pc, 32'd8);
            end else begin
              // Memory will not replay the word, so park it until the stall clears.
              hold_instr <= imem.im_rdata;
              hold_pc    <= pc;
              state      <= HOLD;
              req_q      <= 1'b0;
            end
          end else if (!stall) begin
            ifd_valid <= 1'b0;
            ifd_instr <= 32'd0;
            ifd_pc8   <= 32'd0;
          end
        end

        HOLD: begin
          if (!stall) begin
            ifd_valid <= 1'b1;
            ifd_instr <= hold_instr;
            ifd_pc8   <= pc_offset(hold_pc, 32'd8);
            state     <= FETCH;
            req_q     <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        ifd_valid;
  logic [31:0] ifd_instr;
  logic [31:0] ifd_pc8;

  fetch_sequencer_if imem();

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .ifd_valid   (ifd_valid),
    .ifd_instr   (ifd_instr),
    .ifd_pc8     (ifd_pc8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          tag;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   scen = 0;
  int   step = 0;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h8C01_0000;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if ({imem.im_req, imem.im_addr, ifd_valid, ifd_instr, ifd_pc8} !==
          {e.req, e.addr, e.valid, e.instr, e.pc8}) begin
        n_bad++;
        $display("FAIL vec%0d: got req=%b addr=%h v=%b instr=%h pc8=%h, required req=%b addr=%h v=%b instr=%h pc8=%h",
                 e.tag, imem.im_req, imem.im_addr, ifd_valid, ifd_instr, ifd_pc8,
                 e.req, e.addr, e.valid, e.instr, e.pc8);
      end
    end
  end

  // One clock cycle: drive inputs, queue the outputs expected during this cycle.
  task automatic vec(input logic r, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic ak,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_instr,
                     input logic [31:0] e_pc8);
    exp_t e;
    reset         = r;
    stall         = st;
    redirect      = rd;
    redirect_pc   = rpc;
    imem.im_ack   = ak;
    imem.im_rdata = (ak && e_req) ? ins(e_addr) : 32'hBAD0_0BAD;
    step++;
    e.tag   = scen * 100 + step;
    e.req   = e_req;
    e.addr  = e_addr;
    e.valid = e_v;
    e.instr = e_instr;
    e.pc8   = e_pc8;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Reset, then leave the DUT at the first FETCH cycle for 0x3000.
  task automatic boot(input int s);
    scen = s;
    step = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    imem.im_ack = 1'b0;
    @(posedge clk);
    #1;
    vec(1, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
  endtask

  initial begin
    imem.im_ack   = 1'b0;
    imem.im_rdata = 32'd0;
    @(posedge clk);
    #1;

    // Zero-wait streaming
    boot(1);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 0, 0, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 0, 1, 32'h300C, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h300C, 0, 0, 0);

    // Stall on the ack for 0x3004, stray ack while holding
    boot(2);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 1, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 1, 0, 0, 0, 0, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 1, 0, 0, 1, 0, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 0, 0, 0, 0, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 0, 0, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 0, 1, 32'h300C, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h300C, 0, 0, 0);

    // Redirect in the delay-slot ack cycle
    boot(3);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 1, 32'h3040, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 1, 1, 32'h3040, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h3044, 1, ins(32'h3040), 32'h3048);

    // Redirect before the delay slot arrives: pending target
    boot(4);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 1, 32'h3040, 0, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 0, 1, 32'h3008, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3008, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3040, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h3044, 1, ins(32'h3040), 32'h3048);

    // Redirect under stall is ignored when it is not reissued
    boot(5);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 1, 1, 32'h3040, 0, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 1, 1, 32'h3040, 0, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 0, 1, 32'h300C, 1, ins(32'h3008), 32'h3010);

    // Redirect under stall, held after the stall drops
    boot(6);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 1, 1, 32'h3040, 0, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 1, 32'h3040, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 1, 1, 32'h3040, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h3044, 1, ins(32'h3040), 32'h3048);

    // Reset while waiting for the ack at 0x3010, then a late ack
    boot(7);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 0, 0, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 1, 1, 32'h300C, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h3010, 1, ins(32'h300C), 32'h3014);
    vec(1, 0, 0, 0, 0, 1, 32'h3010, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 0, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0);

    // PC wrap: delay slot taken to the top of the address space
    boot(8);
    vec(0, 0, 0, 0, 1, 1, 32'h3000, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 32'h3004, 1, ins(32'h3000), 32'h3008);
    vec(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h3008, 1, ins(32'h3004), 32'h300C);
    vec(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, ins(32'h3008), 32'h3010);
    vec(0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, ins(32'hFFFF_FFFC), 32'h0000_0004);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
